// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-bit scoreboard for RAW hazard detection.
// Latency: reads are combinational (0 cycles), with optional same-cycle write bypass. Writes and allocs commit on the next rising edge.
// Backpressure: none. Every write and alloc is accepted each cycle; decode stalls on rbusy and any_busy.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 4,
    parameter int NUM_WRITE  = 2,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_READ-1:0][AW-1:0]          ra,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd,
    output logic [NUM_READ-1:0]                  rbusy,
    input  logic [NUM_WRITE-1:0]                 we,
    input  logic [NUM_WRITE-1:0][AW-1:0]         wa,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wd,
    input  logic                                 alloc_valid,
    input  logic [AW-1:0]                        alloc_addr,
    output logic                                 any_busy
);

    // Entry 0 is tied to zero in the next-state logic, so synthesis folds it to a constant.
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 pend_q, pend_d;

    // Next state: writes in ascending port order so the highest port wins. The alloc is applied
    // last because it represents a newer producer than any retiring write.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (we[j] && (wa[j] != '0)) begin
                regs_d[wa[j]] = wd[j];
                pend_d[wa[j]] = 1'b0;
            end
        end
        if (alloc_valid && (alloc_addr != '0)) begin
            pend_d[alloc_addr] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    // State registers. The asynchronous clear discards any write or alloc presented during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Read ports: committed state, overridden by the highest matching write when bypass is enabled.
    // Reset forces zero so that bypassed write data never leaks out during reset.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            rd[i]    = '0;
            rbusy[i] = 1'b0;
            if (!reset && (ra[i] != '0)) begin
                rd[i]    = regs_q[ra[i]];
                rbusy[i] = pend_q[ra[i]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WRITE; j++) begin
                        if (we[j] && (wa[j] == ra[i])) begin
                            rd[i]    = wd[j];
                            rbusy[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Drain and flush indicator. It reflects committed pending bits only.
    always_comb begin
        any_busy = !reset && (|pend_q);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic [3:0][4:0]       ra;
    logic [3:0][31:0]      rd_b, rd_n;
    logic [3:0]            rbusy_b, rbusy_n;
    logic [1:0]            we;
    logic [1:0][4:0]       wa;
    logic [1:0][31:0]      wd;
    logic                  alloc_valid;
    logic [4:0]            alloc_addr;
    logic                  any_busy_b, any_busy_n;

    int   checks;
    int   errors;
    exp_t sb[$];

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .any_busy(any_busy_b)
    );

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wd(wd), .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr), .any_busy(any_busy_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we          = '0;
        wa          = '0;
        wd          = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
    endtask

    task automatic test_reset();
        logic [31:0] obs[$];
        exp_t        e;
        // Reset held with a write to r5 presented; r5 is also being read, so a bypass would be visible.
        ra    = '{5'd31, 5'd5, 5'd1, 5'd0};
        we    = 2'b01;
        wa[0] = 5'd5;
        wd[0] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{name: $sformatf("reset_rd[%0d]", i), val: 32'h0});
            sb.push_back('{name: $sformatf("reset_rbusy[%0d]", i), val: 32'h0});
        end
        sb.push_back('{name: "reset_any_busy", val: 32'h0});
        #2;
        obs = {};
        for (int i = 0; i < 4; i++) begin
            obs.push_back(rd_b[i]);
            obs.push_back(32'(rbusy_b[i]));
        end
        obs.push_back(32'(any_busy_b));
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        // Clock edge while reset is still high: the write must be discarded.
        tick();
        reset = 1'b0;
        idle_inputs();
        sb.push_back('{name: "reset_write_discarded", val: 32'h0});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd_b[2] !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, rd_b[2], e.val);
        end
        // Commit DEADBEEF to r5, then assert reset asynchronously in the middle of the cycle.
        @(negedge clk);
        we    = 2'b01;
        wa[0] = 5'd5;
        wd[0] = 32'hDEADBEEF;
        tick();
        idle_inputs();
        sb.push_back('{name: "r5_committed", val: 32'hDEADBEEF});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd_b[2] !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, rd_b[2], e.val);
        end
        #1 reset = 1'b1;
        sb.push_back('{name: "async_reset_rd_b", val: 32'h0});
        sb.push_back('{name: "async_reset_rd_n", val: 32'h0});
        #1;
        obs = {rd_b[2], rd_n[2]};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_bypass();
        logic [31:0] obs[$];
        exp_t        e;
        @(negedge clk);
        ra    = '{5'd0, 5'd7, 5'd0, 5'd0};
        we    = 2'b01;
        wa[0] = 5'd7;
        wd[0] = 32'h12345678;
        sb.push_back('{name: "bypass_rd_b", val: 32'h12345678});
        sb.push_back('{name: "bypass_rd_n_old", val: 32'h0});
        #1;
        obs = {rd_b[2], rd_n[2]};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        tick();
        idle_inputs();
        sb.push_back('{name: "nobypass_rd_n_next", val: 32'h12345678});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd_n[2] !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, rd_n[2], e.val);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] obs[$];
        exp_t        e;
        @(negedge clk);
        ra    = '{5'd0, 5'd0, 5'd0, 5'd9};
        we    = 2'b11;
        wa[0] = 5'd9;
        wa[1] = 5'd9;
        wd[0] = 32'hAAAA0000;
        wd[1] = 32'h5555FFFF;
        sb.push_back('{name: "conflict_bypass", val: 32'h5555FFFF});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd_b[0] !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, rd_b[0], e.val);
        end
        tick();
        idle_inputs();
        sb.push_back('{name: "conflict_commit_b", val: 32'h5555FFFF});
        sb.push_back('{name: "conflict_commit_n", val: 32'h5555FFFF});
        #1;
        obs = {rd_b[0], rd_n[0]};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] obs[$];
        exp_t        e;
        @(negedge clk);
        ra          = '{5'd0, 5'd0, 5'd0, 5'd3};
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        sb.push_back('{name: "alloc_same_cycle_rbusy", val: 32'h0});
        #1;
        e = sb.pop_front();
        checks++;
        if (32'(rbusy_b[0]) !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, rbusy_b[0], e.val);
        end
        tick();
        idle_inputs();
        sb.push_back('{name: "alloc_rbusy_b", val: 32'h1});
        sb.push_back('{name: "alloc_rbusy_n", val: 32'h1});
        sb.push_back('{name: "alloc_any_busy", val: 32'h1});
        #1;
        obs = {32'(rbusy_b[0]), 32'(rbusy_n[0]), 32'(any_busy_b)};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        we    = 2'b01;
        wa[0] = 5'd3;
        wd[0] = 32'h42;
        sb.push_back('{name: "wb_bypass_rd", val: 32'h42});
        sb.push_back('{name: "wb_bypass_rbusy", val: 32'h0});
        sb.push_back('{name: "wb_nobypass_rbusy", val: 32'h1});
        sb.push_back('{name: "wb_any_busy_committed", val: 32'h1});
        #1;
        obs = {rd_b[0], 32'(rbusy_b[0]), 32'(rbusy_n[0]), 32'(any_busy_b)};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        tick();
        idle_inputs();
        sb.push_back('{name: "wb_after_rbusy", val: 32'h0});
        sb.push_back('{name: "wb_after_any_busy", val: 32'h0});
        sb.push_back('{name: "wb_after_rd_n", val: 32'h42});
        #1;
        obs = {32'(rbusy_b[0]), 32'(any_busy_b), rd_n[0]};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_alloc_write();
        logic [31:0] obs[$];
        exp_t        e;
        @(negedge clk);
        ra          = '{5'd0, 5'd0, 5'd4, 5'd0};
        we          = 2'b10;
        wa[1]       = 5'd4;
        wd[1]       = 32'h99;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd4;
        sb.push_back('{name: "aw_bypass_rd", val: 32'h99});
        sb.push_back('{name: "aw_bypass_rbusy", val: 32'h0});
        #1;
        obs = {rd_b[1], 32'(rbusy_b[1])};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        tick();
        idle_inputs();
        sb.push_back('{name: "aw_next_rd", val: 32'h99});
        sb.push_back('{name: "aw_next_rbusy", val: 32'h1});
        sb.push_back('{name: "aw_next_any_busy", val: 32'h1});
        #1;
        obs = {rd_b[1], 32'(rbusy_b[1]), 32'(any_busy_b)};
        foreach (obs[k]) begin
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
            end
        end
        // Retire r4 so that the pending state is clean for the following scenario.
        we    = 2'b01;
        wa[0] = 5'd4;
        wd[0] = 32'h99;
        tick();
        idle_inputs();
    endtask

    task automatic test_r0();
        logic [31:0] obs[$];
        exp_t        e;
        @(negedge clk);
        ra          = '{5'd0, 5'd0, 5'd0, 5'd0};
        we          = 2'b11;
        wa          = '{5'd0, 5'd0};
        wd          = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        alloc_valid = 1'b1;
        alloc_addr  = 5'd0;
        for (int c = 0; c < 4; c++) begin
            sb.push_back('{name: $sformatf("r0_rd_b_c%0d", c), val: 32'h0});
            sb.push_back('{name: $sformatf("r0_rbusy_b_c%0d", c), val: 32'h0});
            sb.push_back('{name: $sformatf("r0_any_busy_c%0d", c), val: 32'h0});
            sb.push_back('{name: $sformatf("r0_rd_n_c%0d", c), val: 32'h0});
            #1;
            obs = {rd_b[0], 32'(rbusy_b[0]), 32'(any_busy_b), rd_n[0]};
            foreach (obs[k]) begin
                e = sb.pop_front();
                checks++;
                if (obs[k] !== e.val) begin
                    errors++;
                    $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] mregs[32];
        logic        mpend[32];
        logic [31:0] obs[$];
        logic [31:0] xb;
        logic        bb;
        logic        mbusy;
        exp_t        e;
        // Restart from a known state with a short asynchronous reset pulse.
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            mregs[r] = '0;
            mpend[r] = 1'b0;
        end
        for (int c = 0; c < 24; c++) begin
            for (int j = 0; j < 2; j++) begin
                we[j] = 1'($urandom_range(1, 0));
                wa[j] = 5'($urandom_range(7, 0));
                wd[j] = $urandom;
            end
            alloc_valid = 1'($urandom_range(1, 0));
            alloc_addr  = 5'($urandom_range(7, 0));
            for (int i = 0; i < 4; i++) begin
                ra[i] = 5'($urandom_range(7, 0));
            end
            mbusy = 1'b0;
            for (int r = 0; r < 32; r++) mbusy = mbusy | mpend[r];
            for (int i = 0; i < 4; i++) begin
                xb = mregs[ra[i]];
                bb = mpend[ra[i]];
                for (int j = 0; j < 2; j++) begin
                    if (we[j] && wa[j] == ra[i]) begin
                        xb = wd[j];
                        bb = 1'b0;
                    end
                end
                if (ra[i] == 5'd0) begin
                    xb = '0;
                    bb = 1'b0;
                end
                sb.push_back('{name: $sformatf("b2b_c%0d_rd_b[%0d]", c, i), val: xb});
                sb.push_back('{name: $sformatf("b2b_c%0d_rbusy_b[%0d]", c, i), val: 32'(bb)});
                sb.push_back('{name: $sformatf("b2b_c%0d_rd_n[%0d]", c, i), val: mregs[ra[i]]});
                sb.push_back('{name: $sformatf("b2b_c%0d_rbusy_n[%0d]", c, i), val: 32'(mpend[ra[i]])});
            end
            sb.push_back('{name: $sformatf("b2b_c%0d_any_busy", c), val: 32'(mbusy)});
            #1;
            obs = {};
            for (int i = 0; i < 4; i++) begin
                obs.push_back(rd_b[i]);
                obs.push_back(32'(rbusy_b[i]));
                obs.push_back(rd_n[i]);
                obs.push_back(32'(rbusy_n[i]));
            end
            obs.push_back(32'(any_busy_b));
            foreach (obs[k]) begin
                e = sb.pop_front();
                checks++;
                if (obs[k] !== e.val) begin
                    errors++;
                    $display("FAIL %s got %h want %h", e.name, obs[k], e.val);
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] != 5'd0) begin
                    mregs[wa[j]] = wd[j];
                    mpend[wa[j]] = 1'b0;
                end
            end
            if (alloc_valid && alloc_addr != 5'd0) mpend[alloc_addr] = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ra     = '0;
        idle_inputs();
        test_reset();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_alloc_write();
        test_r0();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
